// File: rtl/lfsr_rng.sv
// XNOR Fibonacci LFSR with seed load, lock-up guard and period-wrap pulse.
// Define LFSR_RNG_THRESH_EN to add the threshold/hit comparator.
module lfsr_rng #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'b0000001001,
  parameter logic [WIDTH-1:0] SEED  = 10'h000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
`ifdef LFSR_RNG_THRESH_EN
  input  logic [WIDTH-1:0] threshold,
  output logic             hit,
`endif
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             lockup_fix
);

  localparam logic [WIDTH-1:0] ONES = '1;

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr_rng: WIDTH must be 3..32");
  end
  if (TAPS == '0) begin : g_bad_taps
    $fatal(1, "lfsr_rng: TAPS must be nonzero");
  end
  if (SEED == ONES) begin : g_bad_seed
    $fatal(1, "lfsr_rng: SEED must not be all-ones");
  end

  logic             fb;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] step_val;
  logic             step_lock;
  logic [WIDTH-1:0] ref_seed;

  always_comb begin
    fb        = ~^(out & TAPS);
    nxt       = {fb, out[WIDTH-1:1]};
    step_lock = (nxt == ONES);
    step_val  = step_lock ? SEED : nxt;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      out        <= SEED;
      ref_seed   <= SEED;
      wrap       <= 1'b0;
      lockup_fix <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (seed_in == ONES) begin
        out        <= SEED;
        ref_seed   <= SEED;
        lockup_fix <= 1'b1;
      end else begin
        out        <= seed_in;
        ref_seed   <= seed_in;
        lockup_fix <= 1'b0;
      end
    end else if (en) begin
      out        <= step_val;
      lockup_fix <= step_lock;
      wrap       <= (step_val == ref_seed);
    end else begin
      wrap       <= 1'b0;
      lockup_fix <= 1'b0;
    end
  end

`ifdef LFSR_RNG_THRESH_EN
  // Only a step produces a fresh sample to compare.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hit <= 1'b0;
    end else if (!load && en) begin
      hit <= (step_val < threshold);
    end else begin
      hit <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: reference model built from the stepping rules,
// directed scenarios plus a randomized load/en phase.
module tb_lfsr_rng;

  localparam logic [9:0] TAPS = 10'b0000001001;
  localparam logic [9:0] SEED = 10'h000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [9:0] seed_in = '0;
  logic [9:0] threshold = 10'h250;
  logic [9:0] out;
  logic       wrap;
  logic       lockup_fix;
  logic       hit;

  int checks = 0;
  int errors = 0;

  logic [9:0] m_out, m_ref;
  bit         m_wrap, m_fix, m_hit;

  lfsr_rng #(.WIDTH(10), .TAPS(TAPS), .SEED(SEED)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .seed_in   (seed_in),
`ifdef LFSR_RNG_THRESH_EN
    .threshold (threshold),
    .hit       (hit),
`endif
    .out       (out),
    .wrap      (wrap),
    .lockup_fix(lockup_fix)
  );

`ifndef LFSR_RNG_THRESH_EN
  assign hit = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Successor: XNOR of tapped bits enters at the top, the rest move down.
  function automatic logic [9:0] succ(logic [9:0] s);
    int taps_set;
    logic [9:0] r;
    taps_set = $countones(s & TAPS);
    r = s >> 1;
    if (taps_set % 2 == 0) r = r + 10'h200;
    return r;
  endfunction

  task automatic model_reset();
    m_out = SEED; m_ref = SEED;
    m_wrap = 0; m_fix = 0; m_hit = 0;
  endtask

  task automatic compare_all(string tag);
    check({tag, ".out"}, 32'(out), 32'(m_out));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    check({tag, ".fix"}, 32'(lockup_fix), 32'(m_fix));
`ifdef LFSR_RNG_THRESH_EN
    check({tag, ".hit"}, 32'(hit), 32'(m_hit));
`endif
  endtask

  task automatic tick(string tag, bit l, bit e, logic [9:0] s);
    logic [9:0] v;
    load = l; en = e; seed_in = s;
    @(posedge clk);
    if (l) begin
      m_wrap = 0; m_hit = 0;
      if (s == 10'h3FF) begin
        m_out = SEED; m_ref = SEED; m_fix = 1;
      end else begin
        m_out = s; m_ref = s; m_fix = 0;
      end
    end else if (e) begin
      v = succ(m_out);
      m_fix = (v == 10'h3FF);
      if (m_fix) v = SEED;
      m_out = v;
      m_wrap = (v == m_ref);
      m_hit = (v < threshold);
    end else begin
      m_wrap = 0; m_fix = 0; m_hit = 0;
    end
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    #1 compare_all("rst");
    @(posedge clk); #1;
    compare_all("rst_hold");
    reset = 1'b0;
  endtask

  int wraps, first_wrap;

  initial begin
    load = 0; en = 0;
    do_reset();
    for (int i = 0; i < 5; i++) tick("idle", 0, 0, 10'h0);

    // Full period from reset; first three values are hand-checked too.
    wraps = 0; first_wrap = -1;
    for (int i = 1; i <= 1023; i++) begin
      tick("per", 0, 1, 10'h0);
      if (i == 1) check("seq1", 32'(out), 32'h200);
      if (i == 2) check("seq2", 32'(out), 32'h300);
      if (i == 3) check("seq3", 32'(out), 32'h380);
      if (m_wrap) begin
        wraps++;
        if (first_wrap < 0) first_wrap = i;
      end
    end
    check("wrap_count", 32'(wraps), 32'd1);
    check("wrap_step", 32'(first_wrap), 32'd1023);
    check("wrap_out", 32'(out), 32'(SEED));

    tick("ld_ones", 1, 0, 10'h3FF);
    check("ld_ones_fix", 32'(lockup_fix), 32'd1);
    tick("ld_after", 0, 0, 10'h0);
    tick("ld_155", 1, 1, 10'h155);
    check("ld_155_val", 32'(out), 32'h155);

    wraps = 0;
    for (int i = 1; i <= 1023; i++) begin
      tick("p155", 0, 1, 10'h0);
      if (m_wrap) wraps++;
    end
    check("w155_count", 32'(wraps), 32'd1);
    check("w155_out", 32'(out), 32'h155);

    // Asynchronous reset between edges while stepping.
    for (int i = 0; i < 7; i++) tick("pre", 0, 1, 10'h0);
    #2 reset = 1'b1;
    model_reset();
    #1 compare_all("async_rst");
    @(posedge clk); #1;
    compare_all("async_hold");
    reset = 1'b0;
    tick("post_rst", 0, 0, 10'h0);

    for (int i = 0; i < 400; i++) begin
      bit l, e;
      logic [9:0] s;
      l = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
      threshold = 10'($urandom);
      tick("rnd", l, e, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
